// File: rtl/toyrisc_control.sv
// ToyRISC control unit: fetch/execute/memory sequencer with PC, instruction latch and strobes.
// Optional dataAck timeout is enabled by defining TOYRISC_TIMEOUT_EN.
module toyrisc_control #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        progReq,
    output logic [15:0] progAddr,
    input  logic        progAck,
    input  logic [31:0] progData,
    output logic [31:0] instruction,
    output logic [15:0] incPc,
    output logic        writeEnable,
    input  logic [31:0] leftOp,
    output logic        dataRead,
    output logic        dataWrite,
    input  logic        dataAck,
    output logic        halted,
    output logic        timeoutErr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] branchTarget;
    logic        isLoad;
    logic        execWrites;

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Only 100000 (load) and 100001 (store) reach MEM, so bit 26 alone selects the direction.
    assign isLoad       = ~instruction[26];
    assign execWrites   = (instruction[31:30] != 2'b10);
    assign branchTarget = incPc + {{5{instruction[10]}}, instruction[10:0]};

    assign progAddr    = pc;
    assign progReq     = reset && (state == FETCH);
    assign dataRead    = reset && (state == MEM) && isLoad;
    assign dataWrite   = reset && (state == MEM) && !isLoad;
    assign halted      = reset && (state == HALT);
    assign writeEnable = reset && (((state == EXEC) && execWrites) ||
                                   ((state == MEM) && isLoad && dataAck));

`ifdef TOYRISC_TIMEOUT_EN
    logic [15:0] memCount;
    logic        timeoutFlag;

    assign timeoutErr = timeoutFlag;
`else
    assign timeoutErr = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= '0;
            incPc       <= '0;
`ifdef TOYRISC_TIMEOUT_EN
            memCount    <= '0;
            timeoutFlag <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (progAck) begin
                        instruction <= progData;
                        incPc       <= pc + 16'd1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
`ifdef TOYRISC_TIMEOUT_EN
                    memCount <= '0;
`endif
                    case (instruction[31:30])
                        2'b00: begin
                            pc    <= leftOp[15:0];
                            state <= FETCH;
                        end
                        2'b01, 2'b11: begin
                            pc    <= incPc;
                            state <= FETCH;
                        end
                        default: begin
                            case (instruction[29:26])
                                4'b0000, 4'b0001: state <= MEM;
                                4'b0010: begin
                                    pc    <= (leftOp == 32'd0) ? branchTarget : incPc;
                                    state <= FETCH;
                                end
                                default: state <= HALT;
                            endcase
                        end
                    endcase
                end
                MEM: begin
                    if (dataAck) begin
                        pc    <= incPc;
                        state <= FETCH;
                    end
`ifdef TOYRISC_TIMEOUT_EN
                    else if (memCount == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeoutFlag <= 1'b1;
                        state       <= HALT;
                    end else begin
                        memCount <= memCount + 16'd1;
                    end
`endif
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_toyrisc_control.sv
// Directed self-checking bench for toyrisc_control; the timeout scenario runs when TOYRISC_TIMEOUT_EN is defined.
module tb_toyrisc_control;

    logic        clock;
    logic        reset;
    logic        progReq;
    logic [15:0] progAddr;
    logic        progAck;
    logic [31:0] progData;
    logic [31:0] instruction;
    logic [15:0] incPc;
    logic        writeEnable;
    logic [31:0] leftOp;
    logic        dataRead;
    logic        dataWrite;
    logic        dataAck;
    logic        halted;
    logic        timeoutErr;

    int errors = 0;
    int checks = 0;

    toyrisc_control #(
        .RESET_PC      (16'h0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .progReq    (progReq),
        .progAddr   (progAddr),
        .progAck    (progAck),
        .progData   (progData),
        .instruction(instruction),
        .incPc      (incPc),
        .writeEnable(writeEnable),
        .leftOp     (leftOp),
        .dataRead   (dataRead),
        .dataWrite  (dataWrite),
        .dataAck    (dataAck),
        .halted     (halted),
        .timeoutErr (timeoutErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction word in FETCH; returns settled in EXEC.
    task automatic fetch(input logic [31:0] word);
        progAck  = 1'b1;
        progData = word;
        #1;
        check("fetchReq", {31'd0, progReq}, 32'd1);
        cyc();
        progAck  = 1'b0;
        progData = '0;
        #1;
        check("latched", instruction, word);
    endtask

    initial begin
        reset    = 1'b0;
        progAck  = 1'b0;
        progData = '0;
        leftOp   = '0;
        dataAck  = 1'b0;
        #2;
        check("rstProgReq", {31'd0, progReq}, 32'd0);
        check("rstProgAddr", {16'd0, progAddr}, 32'h0000);
        check("rstInstr", instruction, 32'd0);
        check("rstIncPc", {16'd0, incPc}, 32'd0);
        check("rstStrobes", {28'd0, writeEnable, dataRead, dataWrite, halted}, 32'd0);
        check("rstTimeout", {31'd0, timeoutErr}, 32'd0);
        #10;
        reset = 1'b1;

        // ALU instruction at PC 0
        check("aluAddr", {16'd0, progAddr}, 32'h0000);
        fetch(32'hC4221000);
        check("aluIncPc", {16'd0, incPc}, 32'h0001);
        check("aluWe", {31'd0, writeEnable}, 32'd1);
        cyc();
        check("aluNextAddr", {16'd0, progAddr}, 32'h0001);
        check("aluWeDrop", {31'd0, writeEnable}, 32'd0);

        // Load with ack on the fifth MEM cycle
        fetch(32'h80000000);
        check("ldExecWe", {31'd0, writeEnable}, 32'd0);
        check("ldExecRd", {31'd0, dataRead}, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            dataAck = (i == 4);
            #1;
            check("ldRead", {31'd0, dataRead}, 32'd1);
            check("ldNoWrite", {31'd0, dataWrite}, 32'd0);
            check("ldWe", {31'd0, writeEnable}, (i == 4) ? 32'd1 : 32'd0);
            cyc();
        end
        dataAck = 1'b0;
        #1;
        check("ldNextAddr", {16'd0, progAddr}, 32'h0002);
        check("ldReadDrop", {31'd0, dataRead}, 32'd0);

        // Store, immediate ack, no register write
        fetch(32'h84000000);
        cyc();
        dataAck = 1'b1;
        #1;
        check("stWrite", {31'd0, dataWrite}, 32'd1);
        check("stNoRead", {31'd0, dataRead}, 32'd0);
        check("stNoWe", {31'd0, writeEnable}, 32'd0);
        cyc();
        dataAck = 1'b0;
        check("stNextAddr", {16'd0, progAddr}, 32'h0003);

        // JAL to 0x0010
        leftOp = 32'h0000_0010;
        fetch(32'h00000000);
        check("jalWe", {31'd0, writeEnable}, 32'd1);
        check("jalIncPc", {16'd0, incPc}, 32'h0004);
        cyc();
        check("jalTarget", {16'd0, progAddr}, 32'h0010);

        // Branch-if-zero taken, offset -2
        leftOp = 32'd0;
        fetch(32'h880007FE);
        check("bzNoWe", {31'd0, writeEnable}, 32'd0);
        cyc();
        check("bzTaken", {16'd0, progAddr}, 32'h000F);

        fetch(32'hC4221000);
        cyc();
        check("backTo10", {16'd0, progAddr}, 32'h0010);

        // Branch-if-zero not taken
        leftOp = 32'd1;
        fetch(32'h880007FE);
        cyc();
        check("bzNotTaken", {16'd0, progAddr}, 32'h0011);

        // JAL to 0xFFFF, then JAL at 0xFFFF wraps incPc
        leftOp = 32'h0000_FFFF;
        fetch(32'h00000000);
        cyc();
        check("toFFFF", {16'd0, progAddr}, 32'hFFFF);
        leftOp = 32'h0000_1234;
        fetch(32'h00000000);
        check("wrapIncPc", {16'd0, incPc}, 32'h0000);
        check("wrapWe", {31'd0, writeEnable}, 32'd1);
        cyc();
        check("wrapTarget", {16'd0, progAddr}, 32'h1234);

        // Undefined 101111 halts until reset
        fetch(32'hBC000000);
        check("haltExecWe", {31'd0, writeEnable}, 32'd0);
        progAck  = 1'b1;
        progData = 32'hC4221000;
        cyc();
        for (int i = 0; i < 20; i++) begin
            check("halted", {31'd0, halted}, 32'd1);
            check("haltNoReq", {30'd0, progReq, writeEnable}, 32'd0);
            cyc();
        end
        progAck = 1'b0;
        reset   = 1'b0;
        #1;
        check("haltRstHalted", {31'd0, halted}, 32'd0);
        check("haltRstAddr", {16'd0, progAddr}, 32'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("restartReq", {31'd0, progReq}, 32'd1);
        check("restartAddr", {16'd0, progAddr}, 32'h0000);

        // Reset in the middle of a store drops dataWrite without a clock edge
        fetch(32'h84000000);
        cyc();
        #1;
        check("midMemWrite", {31'd0, dataWrite}, 32'd1);
        reset = 1'b0;
        #1;
        check("abortWrite", {31'd0, dataWrite}, 32'd0);
        check("abortReq", {31'd0, progReq}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("abortRestart", {16'd0, progAddr}, 32'h0000);
        check("abortRestartReq", {31'd0, progReq}, 32'd1);

`ifdef TOYRISC_TIMEOUT_EN
        fetch(32'h84000000);
        cyc();
        for (int i = 0; i < 16; i++) begin
            #1;
            check("toWrite", {31'd0, dataWrite}, 32'd1);
            check("toNotYet", {31'd0, timeoutErr}, 32'd0);
            cyc();
        end
        #1;
        check("toHalted", {31'd0, halted}, 32'd1);
        check("toErr", {31'd0, timeoutErr}, 32'd1);
        check("toStrobes", {29'd0, dataWrite, dataRead, writeEnable}, 32'd0);
`else
        cyc();
        check("noTimeoutErr", {31'd0, timeoutErr}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
